// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: shared APB master state and request types
package apb_uart_pkg;
  localparam int APB_ADDR_WIDTH = 5;
  localparam int APB_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_master_state_e;
  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0]   addr;
    logic                        we;
    logic [APB_DATA_WIDTH-1:0]   wdata;
    logic [APB_DATA_WIDTH/8-1:0] strb;
  } apb_req_t;
endpackage

// File: rtl/memif_apb_master.sv
// memif_apb_master: memory-request to APB4 initiator with bounded pready wait
module memif_apb_master
  import apb_uart_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    mreq_i,
  input  logic [ADDR_WIDTH-1:0]   maddr_i,
  input  logic                    mwe_i,
  input  logic [DATA_WIDTH-1:0]   mwdata_i,
  input  logic [DATA_WIDTH/8-1:0] mstrb_i,
  output logic                    mack_o,
  output logic [DATA_WIDTH-1:0]   mrdata_o,
  output logic                    mresp_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
  } req_t;
  apb_master_state_e state, state_nx;
  req_t              req;
  logic [CW-1:0]     cnt;
  logic              cap, done, tmo;
  assign paddr_o  = req.addr;
  assign pwrite_o = req.we;
  assign pwdata_o = req.wdata;
  assign pstrb_o  = req.strb;
  always_comb begin
    cap      = state == IDLE && mreq_i && !mack_o;
    done     = state == ACCESS && pready_i;
    tmo      = state == ACCESS && !pready_i && TIMEOUT_CYCLES > 0 && cnt + CW'(1) == CW'(TIMEOUT_CYCLES);
    state_nx = cap ? SETUP : state == SETUP ? ACCESS : (done || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      req       <= '0;
      cnt       <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      mack_o    <= 1'b0;
      mrdata_o  <= '0;
      mresp_o   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= state == SETUP ? '0 : (state == ACCESS && !pready_i && cnt != '1) ? cnt + CW'(1) : cnt;
      psel_o    <= state_nx != IDLE;
      penable_o <= state_nx == ACCESS;
      mack_o    <= done || tmo;
      if (cap) begin
        req.addr  <= maddr_i;
        req.we    <= mwe_i;
        req.wdata <= mwdata_i;
        req.strb  <= mwe_i ? mstrb_i : '0;
      end
      if (done || tmo) begin
        mrdata_o <= (done && !req.we) ? prdata_i : '0;
        mresp_o  <= tmo || pslverr_i;
      end
    end
  end
endmodule

// File: tb/tb_memif_apb_master.sv
// tb_memif_apb_master: directed bench with a per-cycle transaction-timeline model
module tb_memif_apb_master;
  localparam int AW = 5, DW = 32, SW = DW / 8, T = 16, N = 1024;
  logic clk = 0, srst = 1, mreq = 0, mwe = 0, pready = 0, pslverr = 0;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwdata = '0, prdata = '0;
  logic [SW-1:0] mstrb = '0;
  logic mack, mresp, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] mrdata, pwdata;
  logic [SW-1:0] pstrb;
  int cyc = 0, checks = 0, errors = 0, free = 0, slv_wait = 0, acc = 0;
  logic chk_en = 0;
  logic e_psel[N], e_pen[N], e_ack[N], e_resp[N], e_we[N], rst_mark[N];
  logic [AW-1:0] e_addr[N];
  logic [DW-1:0] e_wd[N], e_rd[N];
  logic [SW-1:0] e_strb[N];
  logic [DW-1:0] m_rd = '0;
  logic m_resp = 0;
  memif_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .srst_i(srst), .mreq_i(mreq), .maddr_i(maddr), .mwe_i(mwe),
    .mwdata_i(mwdata), .mstrb_i(mstrb), .mack_o(mack), .mrdata_o(mrdata), .mresp_o(mresp),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (psel && penable) begin
      pready = (acc == slv_wait);
      acc++;
    end else begin
      pready = 0;
      acc = 0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic clear_from(input int s);
    for (int i = s; i < N; i++) begin
      e_psel[i] = 0; e_pen[i] = 0; e_ack[i] = 0; e_resp[i] = 0; e_we[i] = 0; rst_mark[i] = 0;
      e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0; e_strb[i] = '0;
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    if (rst_mark[cyc]) begin m_rd = '0; m_resp = 0; end
    if (e_ack[cyc]) begin m_rd = e_rd[cyc]; m_resp = e_resp[cyc]; end
    chk("psel", 64'(psel), 64'(e_psel[cyc]));
    chk("penable", 64'(penable), 64'(e_pen[cyc]));
    chk("mack", 64'(mack), 64'(e_ack[cyc]));
    chk("mrdata", 64'(mrdata), 64'(m_rd));
    chk("mresp", 64'(mresp), 64'(m_resp));
    if (e_psel[cyc]) begin
      chk("paddr", 64'(paddr), 64'(e_addr[cyc]));
      chk("pwrite", 64'(pwrite), 64'(e_we[cyc]));
      chk("pwdata", 64'(pwdata), 64'(e_wd[cyc]));
      chk("pstrb", 64'(pstrb), 64'(e_strb[cyc]));
    end
  end
  task automatic start(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input int w, input logic [DW-1:0] rd, input logic err);
    int e, n, k;
    logic to;
    mreq = 1; maddr = a; mwe = we; mwdata = wd; mstrb = st;
    slv_wait = w; prdata = rd; pslverr = err;
    to = w >= T;
    n = to ? T : w + 1;
    e = (cyc + 1 > free) ? cyc + 1 : free;
    for (int i = 0; i <= n; i++) begin
      e_psel[e+i] = 1; e_pen[e+i] = i > 0; e_addr[e+i] = a; e_we[e+i] = we;
      e_wd[e+i] = wd; e_strb[e+i] = we ? st : '0;
    end
    k = e + n + 1;
    e_ack[k] = 1;
    e_rd[k] = (to || we) ? '0 : rd;
    e_resp[k] = to | err;
    free = k + 2;
  endtask
  task automatic wait_ack(input logic hold, input logic scr, output int k);
    k = -1;
    for (int i = 0; i < 100 && k < 0; i++) begin
      @(negedge clk);
      if (scr && i == 1) begin maddr = ~maddr; mwdata = ~mwdata; mwe = ~mwe; mstrb = ~mstrb; end
      if (mack) k = cyc;
    end
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL ack_wait: got no mack within 100 cycles, expected one");
    end else if (!hold) mreq = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    int c, k, k1;
    clear_from(0);
    repeat (3) @(negedge clk);
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_mack", 64'(mack), 0);
    chk("rst_mrdata", 64'(mrdata), 0);
    chk("rst_mresp", 64'(mresp), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwdata", 64'(pwdata), 0);
    chk("rst_pstrb", 64'(pstrb), 0);
    srst = 0;
    chk_en = 1;
    @(negedge clk);
    c = cyc; start(5'h04, 1, 32'h0000_00A5, 4'hF, 0, 32'h0, 0); wait_ack(0, 0, k);
    chk("w0_latency", 64'(k - c), 3);
    chk("w0_mresp", 64'(mresp), 0);
    repeat (2) @(negedge clk);
    c = cyc; start(5'h10, 0, 32'h1234_5678, 4'hF, 3, 32'hDEAD_BEEF, 0); wait_ack(0, 1, k);
    chk("r3_latency", 64'(k - c), 6);
    chk("r3_mrdata", 64'(mrdata), 64'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    start(5'h08, 1, 32'h55, 4'h3, 1, 32'h0, 1); wait_ack(0, 0, k);
    chk("slverr_mresp", 64'(mresp), 1);
    repeat (2) @(negedge clk);
    c = cyc; start(5'h02, 0, 32'h0, 4'h0, 100, 32'h77, 0); wait_ack(0, 0, k);
    chk("tmo_latency", 64'(k - c), 18);
    chk("tmo_mresp", 64'(mresp), 1);
    chk("tmo_mrdata", 64'(mrdata), 0);
    repeat (2) @(negedge clk);
    c = cyc; start(5'h03, 0, 32'h0, 4'h0, 15, 32'hCAFE_F00D, 0); wait_ack(0, 0, k);
    chk("edge_latency", 64'(k - c), 18);
    chk("edge_mresp", 64'(mresp), 0);
    chk("edge_mrdata", 64'(mrdata), 64'hCAFE_F00D);
    repeat (2) @(negedge clk);
    start(5'h00, 1, 32'h11, 4'hF, 0, 32'h0, 0); wait_ack(1, 0, k1);
    start(5'h08, 1, 32'h22, 4'hF, 0, 32'h0, 0); wait_ack(0, 0, k);
    chk("b2b_period", 64'(k - k1), 4);
    repeat (2) @(negedge clk);
    start(5'h05, 0, 32'h0, 4'h0, 100, 32'h99, 0);
    repeat (4) @(negedge clk);
    srst = 1; mreq = 0;
    clear_from(cyc + 1);
    rst_mark[cyc+1] = 1;
    free = cyc + 2;
    @(negedge clk);
    srst = 0;
    chk("abort_psel", 64'(psel), 0);
    chk("abort_mack", 64'(mack), 0);
    c = cyc; start(5'h06, 1, 32'hABCD, 4'h5, 0, 32'h0, 0); wait_ack(0, 0, k);
    chk("post_rst_latency", 64'(k - c), 3);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memif_apb_master.md
Name: memif_apb_master

Overview:
- APB4 initiator (master) that turns the team's simple memory-request interface (mreq/maddr/mwe/mwdata/mstrb → mack/mrdata/mresp) into APB SETUP/ACCESS transfers.
- It is the opposite end of the APB responder path used in the UART subsystem.
- Uses: driving the UART's APB port from an on-chip controller, and as the bus driver in integration benches.
- Single outstanding transfer, with a bounded wait on pready.

Parameters:
- ADDR_WIDTH, 5, width of maddr_i/paddr_o.
- DATA_WIDTH, 32, data width; a multiple of 8; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- srst_i  in  1  reset, synchronous, active-high.
- mreq_i  in  1  request; held with its fields stable until mack_o is seen.
- maddr_i  in  ADDR_WIDTH  request address.
- mwe_i  in  1  1 = write, 0 = read.
- mwdata_i  in  DATA_WIDTH  write data.
- mstrb_i  in  DATA_WIDTH/8  write byte strobes.
- mack_o  out  1  one-cycle completion pulse.
- mrdata_o  out  DATA_WIDTH  read data; valid while mack_o=1.
- mresp_o  out  1  error flag (pslverr or timeout); valid while mack_o=1.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes.
- pready_i  in  1  APB ready.
- prdata_i  in  DATA_WIDTH  APB read data.
- pslverr_i  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- While srst_i=1 at an edge: state=IDLE; every output and the timeout counter are 0.
- Reset mid-transfer aborts the transfer: no mack_o is produced, and psel_o/penable_o are 0 after that edge.

FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If mreq_i=1 and mack_o=0: capture maddr/mwe/mwdata/mstrb, then go to SETUP.
  - The mack_o=0 qualifier stops a request that is still held during its ack cycle from being re-issued.
- SETUP (exactly 1 cycle):
  - psel_o=1, penable_o=0, paddr/pwrite/pwdata driven from the captured values.
  - pstrb_o = captured strobe on writes, and forced to 0 on reads.
  - Next state: ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; the address, control and data are held unchanged.
  - On pready_i=1: go to IDLE, psel/penable=0, mack_o=1 on the next cycle, mresp_o=pslverr_i.
  - mrdata_o = prdata_i for reads, 0 for writes.
- Timeout:
  - The counter is cleared on entry to ACCESS and increments every ACCESS cycle with pready_i=0.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES while pready_i=0: go to IDLE, psel/penable=0, mack_o=1, mresp_o=1, mrdata_o=0.
  - pready_i=1 in the same cycle the limit is reached takes priority: a normal completion.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
- Latency:
  - mreq_i seen at edge N gives SETUP in N+1 and ACCESS in N+2.
  - Zero-wait pready gives mack_o in N+3.
  - Each wait state adds 1 cycle.
  - Back-to-back: the next SETUP is no earlier than 1 cycle after mack_o, so the minimum period is 4 cycles.
- mack_o is a single-cycle pulse.
- Outside mack_o cycles, mrdata_o and mresp_o hold their last values.
- Input fields changing during SETUP or ACCESS have no effect, because the captured values are used.

Decomposition:
- Add to apb_uart_pkg:
  - the typedef enum apb_master_state_e {IDLE, SETUP, ACCESS};
  - a packed struct apb_req_t {addr, we, wdata, strb}, parameterised by a width localparam or defined at the default widths.
- No sub-module: the FSM, capture register and timeout counter belong in a single module (about 150–200 lines).

Test Plan:
- Zero-wait write: mreq with maddr=0x04, mwe=1, mwdata=0x0000_00A5, mstrb=0xF.
  - psel=1/penable=0 for 1 cycle, then penable=1, pwdata=0xA5, pstrb=0xF.
  - pready=1 immediately gives mack_o 3 cycles after the request, with mresp=0.
- Read with 3 wait states: maddr=0x10, mwe=0; pready low for 3 ACCESS cycles, then high with prdata=0xDEAD_BEEF.
  - mack_o in cycle N+6, with mrdata=0xDEADBEEF.
  - pstrb_o=0 throughout; the address is stable throughout.
- Slave error: a write completes with pready=1, pslverr=1 → mack_o with mresp=1, and the FSM returns to IDLE.
- Timeout, TIMEOUT_CYCLES=16: pready held low.
  - After 16 ACCESS cycles psel/penable drop, and mack_o=1 with mresp=1, mrdata=0.
  - Repeat with pready=1 arriving on the 16th cycle → normal completion, mresp=pslverr.
- Back-to-back with mreq held high across mack_o:
  - exactly one APB transfer per mack_o;
  - the second SETUP starts 1 cycle after the mack_o pulse;
  - the two writes to 0x00 and 0x08 appear in order.
- Reset mid-ACCESS: assert srst_i for 1 cycle during the wait.
  - psel/penable/mack=0 on the next edge, with no ack issued.
  - A following request completes normally.
